// File: rtl/keypad_pkg.sv
// Shared event type, sizing helpers and the lowest-set-bit encoder used by the
// keypad event queue.
package keypad_pkg;

    localparam int KP_MAX_KEYS  = 32;
    localparam int KP_IDX_MAX_W = 5;
    localparam int KP_DBC_W     = 4;
    localparam int KP_REP_W     = 8;

    typedef struct packed {
        logic [KP_IDX_MAX_W-1:0] idx;
        logic                    press;
    } keypad_evt_t;

    function automatic int kp_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int kp_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [KP_IDX_MAX_W-1:0] kp_lowest_set(input logic [KP_MAX_KEYS-1:0] vec);
        logic [KP_IDX_MAX_W-1:0] idx;
        idx = '0;
        for (int i = KP_MAX_KEYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = KP_IDX_MAX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Single-key debouncer: the level flips after DEBOUNCE_TICKS consecutive
// differing samples; toggle pulses combinationally on the flipping edge.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic toggle
);

    logic [KP_DBC_W-1:0] r_cnt;
    logic                r_level;
    logic [KP_DBC_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + KP_DBC_W'(1);
    assign toggle    = tick && (raw != r_level) && (w_cnt_inc == KP_DBC_W'(DEBOUNCE_TICKS));
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (tick) begin
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (toggle) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

endmodule

// File: rtl/keypad_event_queue.sv
// Keypad front end: per-key debounce, pending-bit scanner and event FIFO.
// Optional auto-repeat is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_event_queue
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS       = 16,
    parameter int IDX_W          = 4,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int FIFO_DEPTH     = 4
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 6
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_KEYS-1:0]           keypad_matrix,
    input  logic                          flush,
    output logic [NUM_KEYS-1:0]           key_state,
    output logic                          any_pressed,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [IDX_W-1:0]              evt_key,
    output logic                          evt_press,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count
);

    localparam int PTR_W = kp_ptr_w(FIFO_DEPTH);
    localparam int CNT_W = kp_cnt_w(FIFO_DEPTH);

    logic [NUM_KEYS-1:0]     w_level;
    logic [NUM_KEYS-1:0]     w_toggle;
    logic [NUM_KEYS-1:0]     w_repeat;
    logic [NUM_KEYS-1:0]     w_push_mask;
    logic [NUM_KEYS-1:0]     r_pending;
    logic [KP_MAX_KEYS-1:0]  w_pend_ext;
    logic [KP_MAX_KEYS-1:0]  w_state_ext;
    logic [KP_IDX_MAX_W-1:0] w_sel;
    keypad_evt_t             r_mem [FIFO_DEPTH];
    keypad_evt_t             w_head;
    keypad_evt_t             w_push_evt;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_dbc
            keypad_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_dbc (
                .clk    (clk),
                .reset  (reset),
                .tick   (tick),
                .raw    (keypad_matrix[gi]),
                .level  (w_level[gi]),
                .toggle (w_toggle[gi])
            );
        end
    endgenerate

`ifdef KEYPAD_AUTOREPEAT_EN
    // Countdown to the next repeat; loaded with the initial delay on the press edge.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_rep
            logic [KP_REP_W-1:0] r_rep;
            assign w_repeat[gi] = tick && w_level[gi] && !w_toggle[gi] && (r_rep == KP_REP_W'(1));
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rep <= '0;
                end else if (tick) begin
                    if (w_toggle[gi])
                        r_rep <= w_level[gi] ? '0 : KP_REP_W'(REPEAT_DELAY);
                    else if (w_repeat[gi])
                        r_rep <= KP_REP_W'(REPEAT_RATE);
                    else if (w_level[gi] && r_rep != '0)
                        r_rep <= r_rep - KP_REP_W'(1);
                end
            end
        end
    endgenerate
`else
    assign w_repeat = '0;
`endif

    always_comb begin
        w_pend_ext                 = '0;
        w_pend_ext[NUM_KEYS-1:0]   = r_pending;
        w_state_ext                = '0;
        w_state_ext[NUM_KEYS-1:0]  = w_level;
    end

    assign w_sel       = kp_lowest_set(w_pend_ext);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop       = evt_valid && evt_ready;
    assign w_push      = (|r_pending) && (!w_full || w_pop);
    assign w_push_evt  = '{idx: w_sel, press: w_state_ext[w_sel]};
    assign w_push_mask = w_push ? NUM_KEYS'({{(KP_MAX_KEYS-1){1'b0}}, 1'b1} << w_sel) : '0;

    // Flush discards queued and pending events but keeps anything raised on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else if (flush) begin
            r_pending <= w_toggle | w_repeat;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= ((r_pending & ~w_push_mask) ^ w_toggle) | w_repeat;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_evt;
    end

    assign key_state   = w_level;
    assign any_pressed = |w_level;
    assign evt_valid   = (r_count != '0);
    assign evt_key     = IDX_W'(w_head.idx);
    assign evt_press   = w_head.press;
    assign evt_count   = r_count;

endmodule
